spi_snapshot_tx: RTL
====================

// Module: spi_snapshot_tx
// PURPOSE
//  SPI-slave (mode 0) readout end of the snapshot path. Oversamples asynchronous SS_N/SCLK/MOSI in the clk domain.
//  On SS_N falling edge, freezes data_in into a shift register and serializes it MSB-first on MISO.
//  Simultaneously deserializes MOSI into rx_data. Sits between the fast system logic and the external SPI pads.
// PARAMETERS
//  DATA_WIDTH   8   bits per frame (payload), >= 2
//  SYNC_STAGES  2   synchronizer depth per async input, >= 2
// PORTS
//  clk          in   1           system clock; must be >= 8x SCLK frequency
//  rst          in   1           reset: synchronous, active-high
//  ss_n_async   in   1           SPI chip select, active low, asynchronous
//  sclk_async   in   1           SPI clock, idle low (CPOL=0), asynchronous
//  mosi_async   in   1           SPI master-out data, asynchronous
//  data_in      in   DATA_WIDTH  live data, changing on clk
//  miso         out  1           SPI slave-out data
//  miso_oe      out  1           pad output enable, high while frame active
//  rx_data      out  DATA_WIDTH  last complete received word
//  rx_valid     out  1           one-cycle pulse when rx_data updates
//  busy         out  1           high in any state other than IDLE
//  frame_err    out  1           one-cycle pulse on short/aborted frame (or parity error)
// BEHAVIOUR
//  - Reset: miso=0, miso_oe=0, rx_data=0, rx_valid=0, busy=0, frame_err=0; sync chains preset to ss_n=1, sclk=0, mosi=0; state IDLE.
//  - Each input passes SYNC_STAGES flops, then one edge-detect flop. Edge pulses lag the pin by SYNC_STAGES+1 cycles.
//  - FSM: IDLE -> SHIFT on ss fall: tx_sr<=data_in, bit_cnt<=0, miso<=data_in[MSB] on the next cycle, miso_oe<=1.
//  - SHIFT, sclk rise: rx_sr<={rx_sr,mosi}, bit_cnt++. When bit_cnt reaches FRAME_LEN: rx_data<=rx_sr, rx_valid pulse, -> DONE.
//  - SHIFT, sclk fall: tx_sr shifts left; miso<=next bit (0 once exhausted).
//  - DONE: extra SCLK edges ignored; miso=0; rx_data frozen.
//  - ss rise (any non-IDLE state) -> IDLE, miso_oe<=0, miso<=0. frame_err pulses if state was SHIFT with bit_cnt>0.
//  - ss rise with bit_cnt==0 is a silent deselect (no error).
//  - Simultaneous ss rise and sclk edge in one cycle: ss rise wins; the sclk edge is discarded.
//  - ss fall in DONE is impossible; ss must rise first. ss fall seen only from IDLE.
//  - data_in changes after load never affect the frame in flight.
//  - Reset mid-frame: immediate IDLE. If ss_n is still low after reset, no falling edge is seen, so the block stays IDLE until SS_N cycles high->low.
//  - bit_cnt width = $clog2(FRAME_LEN+1); saturates, no wrap.
// CONFIGURATION
//  SPI_TX_PARITY_EN defined: FRAME_LEN=DATA_WIDTH+1.
//   - After the payload, tx shifts an even-parity bit (^loaded word).
//   - The 9th received bit is checked against ^rx payload. rx_data/rx_valid still update; frame_err pulses the same cycle on mismatch.
//  Undefined: FRAME_LEN=DATA_WIDTH, no parity logic, frame_err only for aborts.
// STRUCTURE
//  - Package spi_snapshot_pkg: state encoding localparams (IDLE, SHIFT, DONE), FRAME_LEN derivation, reset constants for sync chains.
//  - Sub-module cdc_sync_bit #(STAGES, RESET_VAL): N-flop synchronizer, instantiated 3x (ss_n, sclk, mosi).
// TESTING (DATA_WIDTH=8, clk=16x SCLK)
//  1. data_in=0xA5, full 8-clock frame, MOSI=0x3C -> MISO samples 1,0,1,0,0,1,0,1 on SCLK rises; rx_data=0x3C; one rx_valid pulse.
//  2. data_in=0xA5 loaded, then data_in=0xFF mid-frame -> MISO still 0xA5; extra 4 SCLKs after bit 8 -> miso=0, no second rx_valid.
//  3. Deselect after 5 SCLKs -> frame_err one pulse, no rx_valid, rx_data unchanged; next frame (0x5A) completes normally.
//  4. rst high for 1 cycle mid-frame with SS_N held low -> outputs 0, busy=0, ignores SCLK; SS_N high->low then starts a clean frame.
//  5. SS_N low/high with no SCLK -> no frame_err, no rx_valid, miso_oe high only while selected (+sync latency).
//  6. SPI_TX_PARITY_EN: data_in=0xA5 -> 9th bit 0. MOSI 0x3C + parity 1 -> rx_valid and frame_err together. Parity 0 -> no frame_err.

Source files
------------

// File: rtl/spi_snapshot_pkg.sv
// rtl/spi_snapshot_pkg.sv - shared types and constants for spi_snapshot_tx (honours SPI_TX_PARITY_EN)
package spi_snapshot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Synchronizer presets: deselected, clock idle low, data low.
    localparam logic SS_N_RST = 1'b1;
    localparam logic SCLK_RST = 1'b0;
    localparam logic MOSI_RST = 1'b0;

    // Bits per SPI frame: payload, plus one trailing parity bit when enabled.
    function automatic int frame_len(input int data_width);
`ifdef SPI_TX_PARITY_EN
        return data_width + 1;
`else
        return data_width;
`endif
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - multi-flop synchronizer for one asynchronous bit
module cdc_sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic d_sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the pin level one stage further along the chain each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_async};
    end

    // Chain register, preset to the idle level of the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_sync = sync_q[STAGES-1];

endmodule

// File: rtl/spi_snapshot_tx.sv
// rtl/spi_snapshot_tx.sv - SPI mode-0 slave snapshot transmitter/receiver (optional SPI_TX_PARITY_EN)
module spi_snapshot_tx
    import spi_snapshot_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss_n_async,
    input  logic                  sclk_async,
    input  logic                  mosi_async,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int FRAME_LEN = frame_len(DATA_WIDTH);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int SETTLE_W  = $clog2(SYNC_STAGES + 1);

    logic ss_s, sclk_s, mosi_s;

    cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(SS_N_RST)) u_sync_ss (
        .clk(clk), .rst(rst), .d_async(ss_n_async), .d_sync(ss_s)
    );
    cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_RST)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_async(sclk_async), .d_sync(sclk_s)
    );
    cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_RST)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_async(mosi_async), .d_sync(mosi_s)
    );

    state_e                state_q, state_d;
    logic                  ss_prev_q, sclk_prev_q;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic                  armed_q, armed_d;
    logic [FRAME_LEN-1:0]  tx_sr_q, tx_sr_d;
    logic [FRAME_LEN-1:0]  rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic                  ss_fall, ss_rise, sclk_rise, sclk_fall, settled, last_bit;
    logic [FRAME_LEN-1:0]  load_word, rx_sr_shift;
    logic [CNT_W-1:0]      bit_cnt_inc;
`ifdef SPI_TX_PARITY_EN
    logic                  parity_bad;
`endif

    // Edge detection, post-reset settling and frame word helpers.
    always_comb begin
        ss_fall      = ss_prev_q & ~ss_s;
        ss_rise      = ~ss_prev_q & ss_s;
        sclk_rise    = ~sclk_prev_q & sclk_s;
        sclk_fall    = sclk_prev_q & ~sclk_s;
        // The chain presets are flushed once SYNC_STAGES real samples have arrived;
        // a select is only accepted after SS_N has genuinely been seen high, so a
        // pin still held low across reset cannot masquerade as a falling edge.
        settled      = (settle_cnt_q == SETTLE_W'(SYNC_STAGES));
        settle_cnt_d = settled ? settle_cnt_q : settle_cnt_q + SETTLE_W'(1);
        armed_d      = armed_q | (settled & ss_s);
`ifdef SPI_TX_PARITY_EN
        load_word    = {data_in, ^data_in};
`else
        load_word    = data_in;
`endif
        rx_sr_shift  = {rx_sr_q[FRAME_LEN-2:0], mosi_s};
        bit_cnt_inc  = bit_cnt_q + CNT_W'(1);
        last_bit     = (bit_cnt_inc == CNT_W'(FRAME_LEN));
`ifdef SPI_TX_PARITY_EN
        parity_bad   = rx_sr_shift[0] != (^rx_sr_shift[FRAME_LEN-1:1]);
`endif
    end

    // Frame FSM: next state and all registered outputs.
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d   = SHIFT;
                    tx_sr_d   = load_word;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    miso_d    = load_word[FRAME_LEN-1];
                    miso_oe_d = 1'b1;
                end
            end
            SHIFT: begin
                // A deselect in the same cycle as a clock edge discards the edge.
                if (ss_rise) begin
                    state_d     = IDLE;
                    miso_d      = 1'b0;
                    miso_oe_d   = 1'b0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_sr_d = rx_sr_shift;
                    if (bit_cnt_q != CNT_W'(FRAME_LEN)) begin
                        bit_cnt_d = bit_cnt_inc;
                    end
                    if (last_bit) begin
                        state_d    = DONE;
                        miso_d     = 1'b0;
                        rx_data_d  = rx_sr_shift[FRAME_LEN-1 -: DATA_WIDTH];
                        rx_valid_d = 1'b1;
`ifdef SPI_TX_PARITY_EN
                        frame_err_d = parity_bad;
`endif
                    end
                end else if (sclk_fall) begin
                    tx_sr_d = tx_sr_q << 1;
                    miso_d  = tx_sr_q[FRAME_LEN-2];
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
            end
        endcase
    end

    // State, edge-detect and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ss_prev_q    <= SS_N_RST;
            sclk_prev_q  <= SCLK_RST;
            settle_cnt_q <= '0;
            armed_q      <= 1'b0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ss_prev_q    <= ss_s;
            sclk_prev_q  <= sclk_s;
            settle_cnt_q <= settle_cnt_d;
            armed_q      <= armed_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
